// File: rtl/fetch_pkg.sv
// Shared widths, reset address and the {instruction, pc} pair carried by the fetch buffers.
package fetch_pkg;
  localparam int PC_WIDTH = 64;
  localparam int INSTR_WIDTH = 32;
  localparam logic [PC_WIDTH-1:0] RESET_PC = '0;
  localparam int FETCH_STRIDE = 4;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } fetch_pair_t;
endpackage

// File: rtl/fetch_unit_fifo.sv
// Small synchronous FIFO with flush; flush wins over push/pop in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: credit-limited in-order requests, PC/word pairing,
// output buffering toward IF/ID and redirect handling with stale-response dropping.
module fetch_unit #(
  parameter logic [fetch_pkg::PC_WIDTH-1:0] RESET_PC = fetch_pkg::RESET_PC,
  parameter int DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  output logic                             imem_req_valid,
  input  logic                             imem_req_ready,
  output logic [fetch_pkg::PC_WIDTH-1:0]   imem_addr,
  input  logic                             imem_rsp_valid,
  input  logic [fetch_pkg::INSTR_WIDTH-1:0] imem_rsp_data,
  input  logic                             branch_taken,
  input  logic [fetch_pkg::PC_WIDTH-1:0]   branch_target,
  output logic                             fetch_valid,
  input  logic                             fetch_ready,
  output logic [fetch_pkg::INSTR_WIDTH-1:0] Instruction,
  output logic [fetch_pkg::PC_WIDTH-1:0]   PC_Out
);
  import fetch_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;

  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]       outstanding_q, outstanding_d;
  logic [CW-1:0]       drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]       out_count, pc_count;
  logic [SW-1:0]       occupancy;
  logic                req_fire, rsp_any, rsp_drop, rsp_take, pop_out;
  logic                out_empty, out_full, pc_empty, pc_full;
  logic [PC_WIDTH-1:0] rsp_pc;
  fetch_pair_t         push_pair, head_pair;
  logic                unused_fifo_status;

  assign unused_fifo_status = &{1'b0, pc_count, pc_full, out_full};

  // Every credit is either in flight, buffered, or owed to a stale response.
  assign occupancy      = SW'(outstanding_q) + SW'(out_count) + SW'(drop_cnt_q);
  assign imem_req_valid = reset && !branch_taken && (occupancy < SW'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before reset) are ignored.
  assign rsp_any  = imem_rsp_valid && (drop_cnt_q != '0 || outstanding_q != '0);
  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_take = imem_rsp_valid && (drop_cnt_q == '0) && !pc_empty && !branch_taken;

  assign fetch_valid = !out_empty;
  assign pop_out     = fetch_valid && fetch_ready;
  assign Instruction = out_empty ? '0 : head_pair.instr;
  assign PC_Out      = out_empty ? '0 : head_pair.pc;

  assign push_pair.instr = imem_rsp_data;
  assign push_pair.pc    = rsp_pc;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    if (branch_taken) begin
      fetch_pc_d    = {branch_target[PC_WIDTH-1:2], 2'b00};
      outstanding_d = '0;
      drop_cnt_d    = drop_cnt_q + outstanding_q - CW'(rsp_any);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + PC_WIDTH'(FETCH_STRIDE);
      outstanding_d = outstanding_q + CW'(req_fire) - CW'(rsp_take);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  sync_fifo #(.WIDTH(PC_WIDTH), .DEPTH(DEPTH)) pc_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (req_fire),
    .pop     (rsp_take),
    .flush   (branch_taken),
    .wr_data (fetch_pc_q),
    .rd_data (rsp_pc),
    .count   (pc_count),
    .empty   (pc_empty),
    .full    (pc_full)
  );

  sync_fifo #(.WIDTH($bits(fetch_pair_t)), .DEPTH(DEPTH)) out_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (rsp_take),
    .pop     (pop_out),
    .flush   (branch_taken),
    .wr_data (push_pair),
    .rd_data (head_pair),
    .count   (out_count),
    .empty   (out_empty),
    .full    (out_full)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: in-order memory model returning addr>>2, second instance for PC wrap.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid, branch_taken, fetch_valid, fetch_ready;
  logic [63:0] imem_addr, branch_target, PC_Out;
  logic [31:0] imem_rsp_data, Instruction;

  logic        req_valid2, rsp_valid2, fetch_valid2;
  logic [63:0] addr2, pc_out2;
  logic [31:0] rsp_data2, instr2;

  int          checks = 0;
  int          errors = 0;
  logic        br_n, rdy_n, ren_n;
  logic [63:0] tgt_n;
  logic [63:0] q[$];
  logic [63:0] q2[$];
  int          n2 = 0;
  logic [63:0] exp2_pc [4];
  logic [31:0] exp2_in [4];

  always #5 clk = ~clk;

  fetch_unit #(.DEPTH(2)) dut (
    .clk(clk), .reset(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .Instruction(Instruction), .PC_Out(PC_Out)
  );

  fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .DEPTH(2)) dut2 (
    .clk(clk), .reset(rst_n),
    .imem_req_valid(req_valid2), .imem_req_ready(1'b1), .imem_addr(addr2),
    .imem_rsp_valid(rsp_valid2), .imem_rsp_data(rsp_data2),
    .branch_taken(1'b0), .branch_target(64'd0),
    .fetch_valid(fetch_valid2), .fetch_ready(1'b1),
    .Instruction(instr2), .PC_Out(pc_out2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: memory bookkeeping at the edge, then next-cycle inputs driven after the falling edge.
  task automatic tick();
    logic        hs, rs, hs2, rs2;
    logic [63:0] a, a2, h;
    hs  = imem_req_valid & imem_req_ready;
    a   = imem_addr;
    rs  = imem_rsp_valid;
    hs2 = req_valid2;
    a2  = addr2;
    rs2 = rsp_valid2;
    if (fetch_valid2 && n2 < 4) begin
      chk("wrap_pc", pc_out2, exp2_pc[n2]);
      chk("wrap_instr", 64'(instr2), 64'(exp2_in[n2]));
      n2++;
    end
    @(posedge clk);
    if (rs && q.size() != 0) void'(q.pop_front());
    if (hs) q.push_back(a);
    if (rs2 && q2.size() != 0) void'(q2.pop_front());
    if (hs2) q2.push_back(a2);
    @(negedge clk);
    branch_taken  = br_n;
    branch_target = tgt_n;
    fetch_ready   = rdy_n;
    br_n          = 1'b0;
    h = (q.size() != 0) ? q[0] : 64'd0;
    imem_rsp_valid = ren_n && (q.size() != 0);
    imem_rsp_data  = h[33:2];
    h = (q2.size() != 0) ? q2[0] : 64'd0;
    rsp_valid2 = (q2.size() != 0);
    rsp_data2  = h[33:2];
    #1;
  endtask

  task automatic expect_pop(input string tag, input logic [63:0] pc, input logic [31:0] ins);
    int n = 0;
    while (fetch_valid !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    chk({tag, "_pc"}, PC_Out, pc);
    chk({tag, "_instr"}, 64'(Instruction), 64'(ins));
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0;
    branch_taken = 1'b0;
    branch_target = 64'd0;
    fetch_ready = 1'b1;
    rsp_valid2 = 1'b0;
    rsp_data2 = 32'd0;
    br_n = 1'b0;
    tgt_n = 64'd0;
    rdy_n = 1'b1;
    ren_n = 1'b1;
    exp2_pc[0] = 64'hFFFF_FFFF_FFFF_FFF8; exp2_in[0] = 32'hFFFF_FFFE;
    exp2_pc[1] = 64'hFFFF_FFFF_FFFF_FFFC; exp2_in[1] = 32'hFFFF_FFFF;
    exp2_pc[2] = 64'h0;                   exp2_in[2] = 32'h0;
    exp2_pc[3] = 64'h4;                   exp2_in[3] = 32'h1;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("rst_instr", 64'(Instruction), 64'd0);
    chk("rst_pc_out", PC_Out, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);

    // Test 1: start-up stream
    rst_n = 1'b1;
    #1;
    chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c0_addr", imem_addr, 64'd0);
    tick();
    chk("c1_fetch_valid", 64'(fetch_valid), 64'd0);
    chk("c1_addr", imem_addr, 64'd4);
    tick();
    chk("c2_fetch_valid", 64'(fetch_valid), 64'd1);
    chk("c2_pc", PC_Out, 64'd0);
    chk("c2_instr", 64'(Instruction), 64'd0);
    chk("c2_req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    expect_pop("t1_pc4", 64'd4, 32'd1);
    expect_pop("t1_pc8", 64'd8, 32'd2);
    expect_pop("t1_pc12", 64'd12, 32'd3);

    // Test 2: IF/ID stall for 10 cycles
    rdy_n = 1'b0;
    tick();
    tick();
    chk("stall_early_valid", 64'(fetch_valid), 64'd1);
    chk("stall_early_pc", PC_Out, 64'd16);
    chk("stall_early_req", 64'(imem_req_valid), 64'd0);
    repeat (8) tick();
    chk("stall_late_pc", PC_Out, 64'd16);
    chk("stall_late_instr", 64'(Instruction), 64'd4);
    chk("stall_late_req", 64'(imem_req_valid), 64'd0);
    rdy_n = 1'b1;
    tick();
    expect_pop("t2_pc16", 64'd16, 32'd4);
    expect_pop("t2_pc20", 64'd20, 32'd5);
    expect_pop("t2_pc24", 64'd24, 32'd6);

    // Test 3: redirect with two requests outstanding
    ren_n = 1'b0;
    expect_pop("t3_pc28", 64'd28, 32'd7);
    tick();
    chk("t3_full_req", 64'(imem_req_valid), 64'd0);
    chk("t3_full_valid", 64'(fetch_valid), 64'd0);
    chk("t3_full_addr", imem_addr, 64'd40);
    br_n = 1'b1;
    tgt_n = 64'h103;
    tick();
    chk("t3_br_req", 64'(imem_req_valid), 64'd0);
    ren_n = 1'b1;
    tick();
    chk("t3_drop2_req", 64'(imem_req_valid), 64'd0);
    chk("t3_drop2_addr", imem_addr, 64'h100);
    tick();
    chk("t3_drop1_req", 64'(imem_req_valid), 64'd1);
    expect_pop("t3_pc100", 64'h100, 32'h40);
    expect_pop("t3_pc104", 64'h104, 32'h41);

    // Test 4: redirect coinciding with a response and a pop
    br_n = 1'b1;
    tgt_n = 64'h200;
    tick();
    chk("t4_br_valid", 64'(fetch_valid), 64'd1);
    chk("t4_br_pc", PC_Out, 64'h108);
    chk("t4_br_instr", 64'(Instruction), 64'h42);
    chk("t4_br_req", 64'(imem_req_valid), 64'd0);
    tick();
    chk("t4_after_valid", 64'(fetch_valid), 64'd0);
    chk("t4_after_req", 64'(imem_req_valid), 64'd1);
    chk("t4_after_addr", imem_addr, 64'h200);
    expect_pop("t4_pc200", 64'h200, 32'h80);
    expect_pop("t4_pc204", 64'h204, 32'h81);

    // Test 6: reset with one buffered pair and one outstanding request
    rdy_n = 1'b0;
    ren_n = 1'b0;
    tick();
    chk("t6_pre_valid", 64'(fetch_valid), 64'd1);
    chk("t6_pre_pc", PC_Out, 64'h208);
    chk("t6_pre_instr", 64'(Instruction), 64'h82);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(fetch_valid), 64'd0);
    chk("t6_rst_pc", PC_Out, 64'd0);
    chk("t6_rst_instr", 64'(Instruction), 64'd0);
    chk("t6_rst_req", 64'(imem_req_valid), 64'd0);
    chk("t6_rst_addr", imem_addr, 64'd0);
    tick();
    tick();
    rdy_n = 1'b1;
    ren_n = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    chk("t6_rel_req", 64'(imem_req_valid), 64'd1);
    chk("t6_rel_addr", imem_addr, 64'd0);
    expect_pop("t6_pc0", 64'd0, 32'd0);
    expect_pop("t6_pc4", 64'd4, 32'd1);

    chk("wrap_count", 64'(n2), 64'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
